// File: rtl/booth_radix4_multiplier.sv
// Sequential NxN radix-4 Booth multiplier, signed or unsigned per operation.
// Latency 2*(N/2+1)+1 cycles from accept to done; start is ignored (not queued) while busy.
module booth_radix4_multiplier #(
  parameter int N = 8
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic [2*N-1:0] product,
  output logic           done,
  output logic           busy
);

  localparam int W  = N + 2;
  localparam int I  = W / 2;
  localparam int CW = $clog2(I + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADD   = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [W+1:0]          m;
  logic [W+1:0]          acc;
  logic [W-1:0]          q;
  logic                  qm1;
  logic [CW-1:0]         count;

  logic [W+1:0]          m_ext;
  logic [W-1:0]          q_ext;
  logic [W+1:0]          m_x2;
  logic [W+1:0]          pp;
  logic signed [2*W+2:0] shifted;
  logic                  last;

  // Two extra bits let unsigned operands ride the signed datapath unchanged.
  assign m_ext   = {{4{signed_mode & multiplicand[N-1]}}, multiplicand};
  assign q_ext   = {{2{signed_mode & multiplier[N-1]}}, multiplier};
  assign m_x2    = {m[W:0], 1'b0};
  assign shifted = $signed({acc, q, qm1}) >>> 2;
  assign last    = (count == CW'(I - 1));

  always_comb begin
    pp = '0;
    case ({q[1:0], qm1})
      3'b001, 3'b010: pp = m;
      3'b011:         pp = m_x2;
      3'b100:         pp = '0 - m_x2;
      3'b101, 3'b110: pp = '0 - m;
      default:        pp = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_ADD;
      S_ADD:   state_nxt = S_SHIFT;
      S_SHIFT: state_nxt = last ? S_DONE : S_ADD;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m       <= '0;
      acc     <= '0;
      q       <= '0;
      qm1     <= 1'b0;
      count   <= '0;
      product <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            m     <= m_ext;
            acc   <= '0;
            q     <= q_ext;
            qm1   <= 1'b0;
            count <= '0;
          end
        end
        S_ADD: acc <= acc + pp;
        S_SHIFT: begin
          acc   <= shifted[2*W+2:W+1];
          q     <= shifted[W:1];
          qm1   <= shifted[0];
          count <= count + CW'(1);
          // Product is the low 2N bits of {acc,q} after the last shift.
          if (last) product <= shifted[2*N:1];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// Bench for booth_radix4_multiplier: N=8 directed vectors and N=4 exhaustive sweep.
module tb_booth_radix4_multiplier;

  localparam int I8 = 5;
  localparam int I4 = 3;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  always #5 clock = ~clock;

  logic        s8_start = 1'b0, s8_sm = 1'b0;
  logic [7:0]  s8_a = '0, s8_b = '0;
  logic [15:0] s8_p;
  logic        s8_done, s8_busy;

  logic        s4_start = 1'b0, s4_sm = 1'b0;
  logic [3:0]  s4_a = '0, s4_b = '0;
  logic [7:0]  s4_p;
  logic        s4_done, s4_busy;

  booth_radix4_multiplier #(.N(8)) dut8 (
    .clock(clock), .reset_n(reset_n), .start(s8_start), .signed_mode(s8_sm),
    .multiplicand(s8_a), .multiplier(s8_b), .product(s8_p), .done(s8_done), .busy(s8_busy)
  );

  booth_radix4_multiplier #(.N(4)) dut4 (
    .clock(clock), .reset_n(reset_n), .start(s4_start), .signed_mode(s4_sm),
    .multiplicand(s4_a), .multiplier(s4_b), .product(s4_p), .done(s4_done), .busy(s4_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic sm);
    longint ea, eb;
    if (sm) begin ea = longint'($signed(a)); eb = longint'($signed(b)); end
    else    begin ea = longint'(a);          eb = longint'(b);          end
    return 16'(ea * eb);
  endfunction

  function automatic logic [7:0] ref4(input logic [3:0] a, input logic [3:0] b, input logic sm);
    longint ea, eb;
    if (sm) begin ea = longint'($signed(a)); eb = longint'($signed(b)); end
    else    begin ea = longint'(a);          eb = longint'(b);          end
    return 8'(ea * eb);
  endfunction

  // Cycle-level model: an accepted op keeps the unit busy for 2I+1 cycles,
  // the last of which is the done cycle where the product becomes visible.
  int          m8_left = 0, m4_left = 0;
  logic [15:0] m8_prod = '0, m8_pend = '0;
  logic [7:0]  m4_prod = '0, m4_pend = '0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m8_left = 0; m8_prod = '0;
      m4_left = 0; m4_prod = '0;
    end else begin
      if (m8_left == 0) begin
        if (s8_start) begin m8_left = 2*I8 + 1; m8_pend = ref8(s8_a, s8_b, s8_sm); end
      end else begin
        m8_left--;
        if (m8_left == 1) m8_prod = m8_pend;
      end
      if (m4_left == 0) begin
        if (s4_start) begin m4_left = 2*I4 + 1; m4_pend = ref4(s4_a, s4_b, s4_sm); end
      end else begin
        m4_left--;
        if (m4_left == 1) m4_prod = m4_pend;
      end
    end
  end

  always @(negedge clock) begin
    check("product8", 64'(s8_p), 64'(m8_prod));
    check("done8",    64'(s8_done), 64'(m8_left == 1));
    check("busy8",    64'(s8_busy), 64'(m8_left != 0));
    check("product4", 64'(s4_p), 64'(m4_prod));
    check("done4",    64'(s4_done), 64'(m4_left == 1));
    check("busy4",    64'(s4_busy), 64'(m4_left != 0));
  end

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                      output logic [15:0] p, output int lat);
    @(negedge clock); #1;
    s8_a = a; s8_b = b; s8_sm = sm; s8_start = 1'b1;
    @(posedge clock); #1 s8_start = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(negedge clock);
      lat++;
      if (s8_done === 1'b1) break;
    end
    check("done8_seen", 64'(s8_done), 64'(1));
    p = s8_p;
    @(negedge clock);
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic sm,
                      output logic [7:0] p, output int lat);
    @(negedge clock); #1;
    s4_a = a; s4_b = b; s4_sm = sm; s4_start = 1'b1;
    @(posedge clock); #1 s4_start = 1'b0;
    lat = 0;
    while (lat < 30) begin
      @(negedge clock);
      lat++;
      if (s4_done === 1'b1) break;
    end
    check("done4_seen", 64'(s4_done), 64'(1));
    p = s4_p;
    @(negedge clock);
  endtask

  initial begin
    logic [15:0] p8;
    logic [7:0]  p4;
    int          lat;
    int          dn;
    int          wait_cyc;
    logic [15:0] cap;

    #1 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_product", 64'(s8_p), 64'(0));
    check("reset_busy",    64'(s8_busy), 64'(0));
    check("reset_done",    64'(s8_done), 64'(0));
    #1 reset_n = 1'b1;

    run8(8'h80, 8'h80, 1'b1, p8, lat);
    check("m128xm128", 64'(p8), 64'(16'h4000));
    check("latency8", 64'(lat), 64'(11));
    run8(8'h7F, 8'h80, 1'b1, p8, lat);
    check("127xm128", 64'(p8), 64'(16'hC080));
    run8(8'hFF, 8'hFF, 1'b0, p8, lat);
    check("uFFxFF", 64'(p8), 64'(16'hFE01));
    run8(8'h80, 8'h02, 1'b0, p8, lat);
    check("u80x02", 64'(p8), 64'(16'h0100));
    run8(8'h80, 8'h02, 1'b1, p8, lat);
    check("s80x02", 64'(p8), 64'(16'hFF00));

    // Product hold across a new operation.
    run8(8'd6, 8'd7, 1'b1, p8, lat);
    check("6x7", 64'(p8), 64'(42));
    @(negedge clock); #1;
    s8_a = 8'hFF; s8_b = 8'd1; s8_sm = 1'b1; s8_start = 1'b1;
    @(posedge clock); #1 s8_start = 1'b0;
    repeat (5) @(negedge clock);
    check("hold42", 64'(s8_p), 64'(42));
    wait_cyc = 0;
    while (wait_cyc < 40 && s8_done !== 1'b1) begin @(negedge clock); wait_cyc++; end
    check("m1x1", 64'(s8_p), 64'(16'hFFFF));
    @(negedge clock);

    // Start held / re-pulsed with operands changing after capture.
    @(negedge clock); #1;
    s8_a = 8'd3; s8_b = 8'd5; s8_sm = 1'b1; s8_start = 1'b1;
    dn = 0; cap = '0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clock); #1;
      if (c == 0) begin s8_a = 8'd7; s8_b = 8'd7; s8_sm = 1'b0; end
      s8_start = (dn == 0) && (c % 3 != 2);
      @(negedge clock);
      if (s8_done === 1'b1) begin dn++; cap = s8_p; end
    end
    s8_start = 1'b0;
    check("one_done", 64'(dn), 64'(1));
    check("3x5", 64'(cap), 64'(15));

    // Asynchronous reset during the third iteration.
    @(negedge clock); #1;
    s8_a = 8'd9; s8_b = 8'd9; s8_sm = 1'b1; s8_start = 1'b1;
    @(posedge clock); #1 s8_start = 1'b0;
    repeat (5) @(negedge clock);
    #1 reset_n = 1'b0;
    #1;
    check("rst_product", 64'(s8_p), 64'(0));
    check("rst_busy",    64'(s8_busy), 64'(0));
    check("rst_done",    64'(s8_done), 64'(0));
    @(negedge clock); #1 reset_n = 1'b1;
    run8(8'd10, 8'd10, 1'b1, p8, lat);
    check("10x10", 64'(p8), 64'(100));
    check("latency8_rst", 64'(lat), 64'(11));

    // N=4 exhaustive in both modes.
    for (int sm = 0; sm < 2; sm++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          run4(4'(a), 4'(b), sm[0], p4, lat);
          check("n4_product", 64'(p4), 64'(ref4(4'(a), 4'(b), sm[0])));
          check("latency4", 64'(lat), 64'(7));
        end
      end
    end
    run4(4'h8, 4'h8, 1'b1, p4, lat);
    check("n4_m8xm8", 64'(p4), 64'(8'h40));
    run4(4'hF, 4'hF, 1'b0, p4, lat);
    check("n4_uFxF", 64'(p4), 64'(8'hE1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
